// File: rtl/p2s_pkg.sv
// Shared types and defaults for the parallel-to-serial transmitter.
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_CLK_DIV = 2;

endpackage

// File: rtl/p2s_tick.sv
// Half-period divider for the serial clock: pulses half_tick at the end of
// every CLK_DIV-cycle half and tracks which half (phase) is running.
module p2s_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tick,
    output logic phase
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign half_tick = (cnt_q == LAST);
    assign phase     = phase_q;

    // Terminal count is compared explicitly; the counter never wraps on its own.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_tick) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/p2s_shift_out.sv
// Captures a word on start and shifts it MSB-first onto sdata/sclk, then
// pulses slatch and done. All outputs are registered.
module p2s_shift_out
    import p2s_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             sdata,
    output logic             sclk,
    output logic             slatch
);

    localparam int BW = $clog2(WIDTH);

    state_t           state_q;
    // The bit on the wire lives in sdata_q; rest_q holds the bits still to go.
    logic [WIDTH-2:0] rest_q;
    logic [BW-1:0]    bit_q;
    logic             busy_q, done_q, sdata_q, sclk_q, slatch_q;

    logic tick_clr, half_tick, phase;

    assign tick_clr = (state_q == IDLE) || (state_q == DONE);

    p2s_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .clr       (tick_clr),
        .half_tick (half_tick),
        .phase     (phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rest_q   <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sdata_q  <= 1'b0;
            sclk_q   <= 1'b0;
            slatch_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sdata_q <= data[WIDTH-1];
                        rest_q  <= data[WIDTH-2:0];
                        bit_q   <= BW'(WIDTH - 1);
                        sclk_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (half_tick) begin
                        if (!phase) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // End of bit: data moves together with the falling edge.
                            sclk_q <= 1'b0;
                            if (bit_q != '0) begin
                                sdata_q <= rest_q[WIDTH-2];
                                rest_q  <= rest_q << 1;
                                bit_q   <= bit_q - BW'(1);
                            end else begin
                                sdata_q  <= 1'b0;
                                slatch_q <= 1'b1;
                                state_q  <= LATCH;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (half_tick) begin
                        slatch_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign sdata  = sdata_q;
    assign sclk   = sclk_q;
    assign slatch = slatch_q;

endmodule

// File: tb/tb_p2s_shift_out.sv
// Scoreboard bench for p2s_shift_out: a default 32-bit instance and an
// 8-bit instance with CLK_DIV=1, each checked by its own receiver/monitor.
module tb_p2s_shift_out;

    localparam int WA = 32, CDA = 2;
    localparam int WB = 8,  CDB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          start_a = 1'b0;
    logic [WA-1:0] data_a  = '0;
    logic          busy_a, done_a, sdata_a, sclk_a, slatch_a;

    logic          start_b = 1'b0;
    logic [WB-1:0] data_b  = '0;
    logic          busy_b, done_b, sdata_b, sclk_b, slatch_b;

    p2s_shift_out #(.WIDTH(WA), .CLK_DIV(CDA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data(data_a),
        .busy(busy_a), .done(done_a), .sdata(sdata_a), .sclk(sclk_a), .slatch(slatch_a)
    );

    p2s_shift_out #(.WIDTH(WB), .CLK_DIV(CDB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data_b),
        .busy(busy_b), .done(done_b), .sdata(sdata_b), .sclk(sclk_b), .slatch(slatch_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   bexp_q[$];
    int   bdone_q[$];

    // Receiver for instance A: reassembles the word and measures the framing.
    exp_t        e_a;
    logic [31:0] rx_a;
    int          edges_a, busy_len_a, latch_len_a;
    logic        psclk_a = 1'b0, psdata_a = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            rx_a = '0; edges_a = 0; busy_len_a = 0; latch_len_a = 0;
        end else begin
            if (sclk_a && !psclk_a) begin
                rx_a = {rx_a[30:0], sdata_a};
                edges_a++;
            end
            if (sclk_a) check("a_sdata_stable", sdata_a, psdata_a);
            if (busy_a) busy_len_a++;
            if (slatch_a) latch_len_a++;
            if (done_a) begin
                check("a_done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_a = exp_q.pop_front();
                    $display("A transfer: word=0x%08h rx=0x%08h edges=%0d busy=%0d latch=%0d done@T0+%0d",
                             e_a.word, rx_a, edges_a, busy_len_a, latch_len_a, cyc - e_a.t0);
                    check("a_word", rx_a, e_a.word);
                    check("a_edges", edges_a, WA);
                    check("a_latch_len", latch_len_a, CDA);
                    check("a_busy_len", busy_len_a, (2 * WA + 1) * CDA);
                    check("a_done_time", cyc - e_a.t0, 1 + (2 * WA + 1) * CDA);
                end
                rx_a = '0; edges_a = 0; busy_len_a = 0; latch_len_a = 0;
            end
        end
        psclk_a  = sclk_a;
        psdata_a = sdata_a;
    end

    // Receiver for instance B: bit-by-bit comparison and sclk toggle check.
    logic psclk_b = 1'b0, psdata_b = 1'b0, pshift_b = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (sclk_b && !psclk_b) begin
                check("b_bit_expected", bexp_q.size() > 0, 1);
                if (bexp_q.size() > 0) check("b_sdata_bit", sdata_b, bexp_q.pop_front());
            end
            if (sclk_b) check("b_sdata_stable", sdata_b, psdata_b);
            if (pshift_b && busy_b && !slatch_b) check("b_sclk_toggle", sclk_b, !psclk_b);
            if (done_b) begin
                check("b_done_expected", bdone_q.size() > 0, 1);
                check("b_bits_left", bexp_q.size(), 0);
                if (bdone_q.size() > 0) check("b_done_time", cyc, bdone_q.pop_front());
                $display("B transfer: done at cycle %0d", cyc);
            end
        end
        psclk_b  = sclk_b;
        psdata_b = sdata_b;
        pshift_b = busy_b && !slatch_b;
    end

    // Called at a negedge: start is high for exactly the following cycle.
    task automatic issue_a(input logic [31:0] w, output int t0);
        t0 = cyc;
        start_a = 1'b1;
        data_a  = w;
        exp_q.push_back('{word: w, t0: cyc});
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("a_done_seen", done_a, 1);
    endtask

    initial begin
        int t0;
        int n;

        repeat (3) @(negedge clk);
        check("a_reset_outputs", {busy_a, done_a, sdata_a, sclk_a, slatch_a}, 5'b0);
        check("b_reset_outputs", {busy_b, done_b, sdata_b, sclk_b, slatch_b}, 5'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8-bit word 0x81 at CLK_DIV=1: bits 1,0,0,0,0,0,0,1, done at T0+18.
        start_b = 1'b1;
        data_b  = 8'h81;
        foreach (bexp_q[i]) bexp_q.delete(i);
        bexp_q.push_back(1); bexp_q.push_back(0); bexp_q.push_back(0); bexp_q.push_back(0);
        bexp_q.push_back(0); bexp_q.push_back(0); bexp_q.push_back(0); bexp_q.push_back(1);
        bdone_q.push_back(cyc + 18);
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b_done_seen", done_b, 1);
        repeat (3) @(negedge clk);

        // Default instance, plain transfer.
        issue_a(32'hA5A5_0F0F, t0);
        wait_done_a(300);
        repeat (3) @(negedge clk);

        // Extra starts mid-transfer and in the DONE cycle are ignored; data changes too.
        issue_a(32'hFFFF_FFFF, t0);
        data_a = '0;
        while (cyc < t0 + 40) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(300);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (150) @(negedge clk);
        check("a_idle_after_ignored", {busy_a, done_a}, 2'b00);

        // Asynchronous reset at T0+45 aborts without a latch pulse.
        issue_a(32'h0F0F_F0F0, t0);
        while (cyc < t0 + 45) @(negedge clk);
        check("a_busy_before_rst", busy_a, 1);
        rst = 1'b1;
        #1;
        check("a_rst_outputs", {busy_a, done_a, sdata_a, sclk_a, slatch_a}, 5'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("a_slatch_in_rst", slatch_a, 0);
        rst = 1'b0;
        @(negedge clk);
        issue_a(32'h1234_5678, t0);
        wait_done_a(300);
        repeat (2) @(negedge clk);

        // Back-to-back: start in the cycle after done is accepted.
        issue_a(32'hC3C3_3C3C, t0);
        wait_done_a(300);
        check("b2b_busy_at_done", busy_a, 0);
        @(negedge clk);
        check("b2b_busy_gap", busy_a, 0);
        issue_a(32'h0000_0001, t0);
        check("b2b_accepted", busy_a, 1);
        wait_done_a(300);
        repeat (3) @(negedge clk);

        check("a_queue_empty", exp_q.size(), 0);
        check("b_queue_empty", bdone_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
